// File: rtl/fp16_pkg.sv
// Shared definitions for the fp16 multiply/add datapath: field widths,
// special encodings, the unpacked-operand record and the multiplier's
// stage-register layouts. FP16_MUL_RNE_EN widens the first stage to keep
// the low product bits needed for round-to-nearest-even.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;
    localparam int EXI_W = 7;

    localparam logic [15:0]      NAN_VAL = 16'h7E00;
    localparam logic [15:0]      POS_INF = 16'h7C00;
    localparam logic [15:0]      NEG_INF = 16'hFC00;
    localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

`ifdef FP16_MUL_RNE_EN
    localparam int PROD_KEEP_W = 22;
`else
    localparam int PROD_KEEP_W = 12;
`endif

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mant;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
    } fp16_unp_t;

    localparam int UNP_W = $bits(fp16_unp_t);

    typedef struct packed {
        logic                   valid;
        logic                   sign;
        logic                   special;
        logic [15:0]            special_p;
        logic [EXI_W-1:0]       exp;
        logic [PROD_KEEP_W-1:0] prod;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic             special;
        logic [15:0]      special_p;
        logic [EXI_W-1:0] exp;
        logic [MAN_W-1:0] mant;
`ifdef FP16_MUL_RNE_EN
        logic             guard;
        logic             sticky;
`endif
    } s2_t;

endpackage

// File: rtl/fp16_unpack.sv
// Combinational binary16 field splitter and classifier.
// Subnormals (exp==0) are classed as zero so the datapath flushes them.
module fp16_unpack
    import fp16_pkg::*;
(
    input  logic [15:0]      op,
    output logic [UNP_W-1:0] fields
);

    fp16_unp_t f_s;

    // split the fields and flag zero / inf / NaN
    always_comb begin
        f_s.sign    = op[15];
        f_s.exp     = op[14:10];
        f_s.mant    = op[9:0];
        f_s.is_zero = (op[14:10] == 5'h00);
        f_s.is_inf  = (op[14:10] == EXP_MAX) && (op[9:0] == 10'h000);
        f_s.is_nan  = (op[14:10] == EXP_MAX) && (op[9:0] != 10'h000);
    end

    assign fields = f_s;

endmodule

// File: rtl/fp16_mul_pipe.sv
// 3-stage binary16 multiplier: S1 unpack/multiply, S2 normalize,
// S3 round/pack into registered outputs. One global enable stalls every
// stage while the output holds an unconsumed product.
// Build option: FP16_MUL_RNE_EN selects round-to-nearest-even,
// otherwise the result is truncated toward zero.
module fp16_mul_pipe
    import fp16_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [15:0] P,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        OVF,
    output logic        UNF
);

    logic             en_s;
    fp16_unp_t        ua_s;
    fp16_unp_t        ub_s;
    logic [21:0]      sig_a_s;
    logic [21:0]      sig_b_s;
    logic [21:0]      prod_full_s;
    logic             nan_s;
    logic             inf_s;
    logic             zero_s;
    s1_t              s1_d_s;
    s1_t              s1_r;
    s2_t              s2_d_s;
    s2_t              s2_r;
    logic [EXI_W-1:0] exp_rnd_s;
    logic [MAN_W-1:0] mant_rnd_s;
    logic [15:0]      p_d_s;
    logic             ovf_d_s;
    logic             unf_d_s;
`ifdef FP16_MUL_RNE_EN
    logic             round_up_s;
    logic [MAN_W:0]   mant_sum_s;
`else
    logic [9:0]       prod_unused_s;
`endif

    assign en_s     = !OUT_VALID || OUT_READY;
    assign IN_READY = en_s;

    fp16_unpack u_unpack_a (.op(A), .fields(ua_s));
    fp16_unpack u_unpack_b (.op(B), .fields(ub_s));

    assign sig_a_s     = {11'h000, 1'b1, ua_s.mant};
    assign sig_b_s     = {11'h000, 1'b1, ub_s.mant};
    assign prod_full_s = sig_a_s * sig_b_s;
`ifndef FP16_MUL_RNE_EN
    assign prod_unused_s = prod_full_s[9:0];
`endif

    // S1: resolve special operands by priority, multiply significands, add exponents
    always_comb begin
        nan_s  = ua_s.is_nan || ub_s.is_nan ||
                 (ua_s.is_inf && ub_s.is_zero) || (ua_s.is_zero && ub_s.is_inf);
        inf_s  = ua_s.is_inf || ub_s.is_inf;
        zero_s = ua_s.is_zero || ub_s.is_zero;
        s1_d_s.valid = IN_VALID;
        s1_d_s.sign  = ua_s.sign ^ ub_s.sign;
        s1_d_s.exp   = {2'b00, ua_s.exp} + {2'b00, ub_s.exp} - 7'(BIAS);
`ifdef FP16_MUL_RNE_EN
        s1_d_s.prod  = prod_full_s;
`else
        s1_d_s.prod  = prod_full_s[21:10];
`endif
        if (nan_s) begin
            s1_d_s.special   = 1'b1;
            s1_d_s.special_p = NAN_VAL;
        end else if (inf_s) begin
            s1_d_s.special   = 1'b1;
            s1_d_s.special_p = s1_d_s.sign ? NEG_INF : POS_INF;
        end else if (zero_s) begin
            s1_d_s.special   = 1'b1;
            s1_d_s.special_p = {s1_d_s.sign, 15'h0000};
        end else begin
            s1_d_s.special   = 1'b0;
            s1_d_s.special_p = 16'h0000;
        end
    end

    // S2: normalize the 22-bit product so the hidden one sits above the mantissa
    always_comb begin
        s2_d_s.valid     = s1_r.valid;
        s2_d_s.sign      = s1_r.sign;
        s2_d_s.special   = s1_r.special;
        s2_d_s.special_p = s1_r.special_p;
        if (s1_r.prod[PROD_KEEP_W-1]) begin
            s2_d_s.exp  = s1_r.exp + 7'd1;
            s2_d_s.mant = s1_r.prod[PROD_KEEP_W-2 -: MAN_W];
        end else begin
            s2_d_s.exp  = s1_r.exp;
            s2_d_s.mant = s1_r.prod[PROD_KEEP_W-3 -: MAN_W];
        end
`ifdef FP16_MUL_RNE_EN
        if (s1_r.prod[21]) begin
            s2_d_s.guard  = s1_r.prod[10];
            s2_d_s.sticky = |s1_r.prod[9:0];
        end else begin
            s2_d_s.guard  = s1_r.prod[9];
            s2_d_s.sticky = |s1_r.prod[8:0];
        end
`endif
    end

    // S3: round (or truncate), then select special / overflow / underflow / normal
    always_comb begin
`ifdef FP16_MUL_RNE_EN
        round_up_s = s2_r.guard && (s2_r.sticky || s2_r.mant[0]);
        mant_sum_s = {1'b0, s2_r.mant} + {10'h000, round_up_s};
        if (mant_sum_s[MAN_W]) begin
            exp_rnd_s  = s2_r.exp + 7'd1;
            mant_rnd_s = 10'h000;
        end else begin
            exp_rnd_s  = s2_r.exp;
            mant_rnd_s = mant_sum_s[MAN_W-1:0];
        end
`else
        exp_rnd_s  = s2_r.exp;
        mant_rnd_s = s2_r.mant;
`endif
        p_d_s   = 16'h0000;
        ovf_d_s = 1'b0;
        unf_d_s = 1'b0;
        if (s2_r.special) begin
            p_d_s = s2_r.special_p;
        end else if (!exp_rnd_s[EXI_W-1] && (exp_rnd_s >= 7'd31)) begin
            p_d_s   = {s2_r.sign, EXP_MAX, 10'h000};
            ovf_d_s = 1'b1;
        end else if (exp_rnd_s[EXI_W-1] || (exp_rnd_s == 7'd0)) begin
            p_d_s   = {s2_r.sign, 15'h0000};
            unf_d_s = 1'b1;
        end else begin
            p_d_s = {s2_r.sign, exp_rnd_s[EXP_W-1:0], mant_rnd_s};
        end
    end

    // pipeline and output registers; all advance together or all hold
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_r      <= '0;
            s2_r      <= '0;
            P         <= 16'h0000;
            OUT_VALID <= 1'b0;
            OVF       <= 1'b0;
            UNF       <= 1'b0;
        end else if (en_s) begin
            s1_r      <= s1_d_s;
            s2_r      <= s2_d_s;
            P         <= p_d_s;
            OUT_VALID <= s2_r.valid;
            OVF       <= ovf_d_s & s2_r.valid;
            UNF       <= unf_d_s & s2_r.valid;
        end else begin
            s1_r      <= s1_r;
            s2_r      <= s2_r;
            P         <= P;
            OUT_VALID <= OUT_VALID;
            OVF       <= OVF;
            UNF       <= UNF;
        end
    end

endmodule

// File: tb/tb_fp16_mul_pipe.sv
// Directed self-checking bench for fp16_mul_pipe: single-op vectors with
// exact latency, a stalled back-to-back stream, and async reset mid-flight.
module tb_fp16_mul_pipe;

    logic        CLK;
    logic        RESET;
    logic [15:0] A;
    logic [15:0] B;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] P;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OVF;
    logic        UNF;

    int checks   = 0;
    int failures = 0;

    fp16_mul_pipe dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .A         (A),
        .B         (B),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .P         (P),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OVF       (OVF),
        .UNF       (UNF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // one op with an idle pipe: accept, verify output stays low two cycles, then result
    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_p, input logic exp_ovf, input logic exp_unf);
        A = a;
        B = b;
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        #1;
        check_val({tag, "_inrdy"}, {15'h0, IN_READY}, 16'h0001);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        check_val({tag, "_lat1"}, {15'h0, OUT_VALID}, 16'h0000);
        @(posedge CLK); #1;
        check_val({tag, "_lat2"}, {15'h0, OUT_VALID}, 16'h0000);
        @(posedge CLK); #1;
        check_val({tag, "_valid"}, {15'h0, OUT_VALID}, 16'h0001);
        check_val({tag, "_p"},     P, exp_p);
        check_val({tag, "_ovf"},   {15'h0, OVF}, {15'h0, exp_ovf});
        check_val({tag, "_unf"},   {15'h0, UNF}, {15'h0, exp_unf});
        @(posedge CLK); #1;
    endtask

    // five ops back-to-back, consumer stalls for cycles 4..7
    task automatic run_stream();
        logic [15:0] sa [5];
        logic [15:0] sb [5];
        logic [15:0] sp [5];
        logic [15:0] held_p;
        int in_idx  = 0;
        int out_idx = 0;
        sa = '{16'h3C00, 16'h4000, 16'h4200, 16'h3800, 16'hC400};
        sb = '{16'h4000, 16'h4000, 16'h4000, 16'h3800, 16'h4000};
        sp = '{16'h4000, 16'h4400, 16'h4600, 16'h3400, 16'hC800};
        held_p = 16'h0000;
        for (int c = 0; c < 40; c++) begin
            OUT_READY = (c >= 4 && c <= 7) ? 1'b0 : 1'b1;
            if (in_idx < 5) begin
                IN_VALID = 1'b1;
                A = sa[in_idx];
                B = sb[in_idx];
            end else begin
                IN_VALID = 1'b0;
            end
            @(negedge CLK);
            if (c <= 12)
                check_val($sformatf("stream_inrdy_c%0d", c), {15'h0, IN_READY}, {15'h0, OUT_READY});
            if (c == 4) begin
                check_val("stream_stall_valid", {15'h0, OUT_VALID}, 16'h0001);
                held_p = P;
            end
            if (c >= 5 && c <= 7)
                check_val($sformatf("stream_hold_c%0d", c), P, held_p);
            if (OUT_VALID && OUT_READY) begin
                if (out_idx < 5)
                    check_val($sformatf("stream_out%0d", out_idx), P, sp[out_idx]);
                else
                    check_val("stream_extra", 16'(out_idx), 16'd4);
                out_idx++;
            end
            if (IN_VALID && IN_READY)
                in_idx++;
            @(posedge CLK); #1;
        end
        check_val("stream_count", 16'(out_idx), 16'd5);
        check_val("stream_accepted", 16'(in_idx), 16'd5);
    endtask

    logic [15:0] va [13];
    logic [15:0] vb [13];
    logic [15:0] vp [13];
    logic        vo [13];
    logic        vu [13];

    initial begin
        va = '{16'h3C00, 16'hC000, 16'h3E00, 16'h3E01, 16'h7800, 16'h0400, 16'h8400,
               16'h7C00, 16'h7C00, 16'h0001, 16'h4000, 16'h7E00, 16'hFC00};
        vb = '{16'h3C00, 16'h4200, 16'h3E00, 16'h3E01, 16'h4000, 16'h0400, 16'h0400,
               16'h0000, 16'hC000, 16'h4000, 16'h4000, 16'h3C00, 16'h0000};
`ifdef FP16_MUL_RNE_EN
        vp = '{16'h3C00, 16'hC600, 16'h4080, 16'h4082, 16'h7C00, 16'h0000, 16'h8000,
               16'h7E00, 16'hFC00, 16'h0000, 16'h4400, 16'h7E00, 16'h7E00};
`else
        vp = '{16'h3C00, 16'hC600, 16'h4080, 16'h4081, 16'h7C00, 16'h0000, 16'h8000,
               16'h7E00, 16'hFC00, 16'h0000, 16'h4400, 16'h7E00, 16'h7E00};
`endif
        vo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vu = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        RESET     = 1'b1;
        A         = 16'h0000;
        B         = 16'h0000;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLK);
        @(posedge CLK); #1;
        check_val("rst_valid", {15'h0, OUT_VALID}, 16'h0000);
        check_val("rst_p",     P, 16'h0000);
        check_val("rst_ovf",   {15'h0, OVF}, 16'h0000);
        check_val("rst_unf",   {15'h0, UNF}, 16'h0000);
        check_val("rst_inrdy", {15'h0, IN_READY}, 16'h0001);
        RESET = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 13; i++)
            run_one($sformatf("vec%0d", i), va[i], vb[i], vp[i], vo[i], vu[i]);

        run_stream();

        // three ops in flight, then asynchronous reset between edges
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        A = 16'h3C00; B = 16'h3C00;
        @(posedge CLK); #1;
        A = 16'h4000; B = 16'h4000;
        @(posedge CLK); #1;
        A = 16'h4200; B = 16'h4000;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        check_val("prerst_valid", {15'h0, OUT_VALID}, 16'h0001);
        check_val("prerst_p",     P, 16'h3C00);
        RESET = 1'b1;
        #1;
        check_val("midrst_valid", {15'h0, OUT_VALID}, 16'h0000);
        check_val("midrst_p",     P, 16'h0000);
        @(posedge CLK);
        @(posedge CLK); #1;
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #1;
            check_val($sformatf("postrst_idle%0d", k), {15'h0, OUT_VALID}, 16'h0000);
        end
        run_one("postrst", 16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp16_mul_pipe.md
Name: fp16_mul_pipe

Overview:
- 3-stage pipelined IEEE-754 binary16 multiplier; the multiply stage of the float MAC.
- Output P feeds the fp16 adder's A operand; the adder adds it to the accumulator.
- Valid/ready handshake on both sides; throughput 1 product/cycle when not stalled.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored mantissa field width.
- BIAS, 15, exponent bias.
- NAN_VAL, 16'h7E00, canonical quiet NaN emitted on invalid operations.

Ports:
- CLK  in  1  clock; all flops on posedge.
- RESET  in  1  asynchronous, active-high reset.
- A  in  16  operand A {sign, exp, mant}.
- B  in  16  operand B.
- IN_VALID  in  1  A/B valid this cycle.
- IN_READY  out  1  block accepts A/B this cycle.
- P  out  16  product.
- OUT_VALID  out  1  P valid.
- OUT_READY  in  1  consumer accepts P.
- OVF  out  1  product overflowed to ±inf; qualified by OUT_VALID.
- UNF  out  1  nonzero product flushed to ±0; qualified by OUT_VALID.

Behaviour:
- Reset (async, active-high): all stage valids=0, P=0, OUT_VALID=0, OVF=0, UNF=0. Reset mid-stream drops every in-flight op.
- Global advance: en = !OUT_VALID | OUT_READY. IN_READY = en (combinational).
- Input accepted when IN_VALID & IN_READY.
- When en=0, all stage registers hold; P/OVF/UNF stay stable while OUT_VALID & !OUT_READY.
- Latency: 3 cycles, accept edge to OUT_VALID, when en stays 1. Bubbles propagate as valid=0.
- S1 (unpack/multiply):
  - sign = sA ^ sB.
  - Special class per operand: zero if exp==0 (subnormals flushed to zero); inf if exp==31 & mant==0; NaN if exp==31 & mant!=0.
  - Significands {1,mant} multiplied, 11x11 -> 22 bits.
  - Biased exponent e = eA + eB - BIAS, held as 7-bit signed.
- S2 (normalize):
  - If prod[21]=1: significand = prod[21:11], e += 1, guard = prod[10], sticky = |prod[9:0].
  - Else: significand = prod[20:10], guard = prod[9], sticky = |prod[8:0].
- S3 (round/pack):
  - Rounding mode per Optional Feature.
  - Rounding carry-out of the mantissa: e += 1, mantissa = 0.
  - e >= 31: P = {sign, 5'h1F, 10'h0}, OVF=1.
  - e <= 0 with nonzero operands: P = {sign, 15'h0}, UNF=1.
- Special-case priority, highest first:
  1. NaN operand, or inf × zero: P = NAN_VAL.
  2. inf operand: P = {sign, inf}.
  3. zero operand: P = {sign, 0}.
  4. Otherwise: the normal path above.
  Specials never set OVF/UNF.
- Simultaneous accept and drain in one cycle is legal; no drop, no duplicate.

Optional Feature:
- Macro: FP16_MUL_RNE_EN.
- Defined: S3 rounds to nearest-even; round-up = guard & (sticky | lsb).
- Undefined: truncation (round toward zero); guard/sticky logic not instantiated; arithmetic matches the adder's truncating datapath.

Decomposition:
- Shared package fp16_pkg:
  - field widths, BIAS, NAN_VAL, POS_INF / NEG_INF constants.
  - unpacked-operand typedef {sign, exp, mant, is_zero, is_inf, is_nan}.
  - stage-register struct types.
  - The adder will adopt the same package.
- One sub-module: fp16_unpack (pure combinational classifier), instantiated twice in S1.
- Pipeline registers, multiply, normalize and round stay in fp16_mul_pipe.

Test Plan:
- 0x3C00×0x3C00, OUT_READY=1 -> P=0x3C00 exactly 3 cycles after accept. Also 0xC000×0x4200 -> 0xC600. OVF=UNF=0.
- 0x3E00×0x3E00 -> 0x4080 (2.25, exponent bump path). 0x3E01×0x3E01 -> 0x4081 truncating; 0x4082 with FP16_MUL_RNE_EN.
- 0x7800×0x4000 -> 0x7C00, OVF=1. 0x0400×0x0400 -> 0x0000, UNF=1. 0x8400×0x0400 -> 0x8000, UNF=1.
- 0x7C00×0x0000 -> 0x7E00. 0x7C00×0xC000 -> 0xFC00. 0x0001×0x4000 -> 0x0000 (subnormal flush, UNF=0).
- Stream 5 ops back-to-back, OUT_READY low for 4 cycles mid-stream -> IN_READY low same cycles, P held stable, all 5 results in order, none lost or duplicated.
- RESET asserted with 3 ops in flight -> OUT_VALID=0, P=0 immediately (async). After release, a new 0x3C00×0x3C00 returns 0x3C00 at latency 3.
